// File: rtl/ringbuffer_pkg.sv
// Shared constants and helpers for the capture-record ring buffer.
package ringbuffer_pkg;

  localparam int RB_MODE_DROP      = 0;
  localparam int RB_MODE_OVERWRITE = 1;

  function automatic int rb_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/ringbuffer_ram.sv
// Simple dual-port storage for the ring buffer: sync write,
// registered read with read-enable (read-first on collision).
module ringbuffer_ram
  import ringbuffer_pkg::*;
#(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = rb_depth(AW);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ringbuffer_multimode.sv
// Ring buffer with level tracking, drop/overwrite overflow
// policy, sticky error flags and a saturating drop counter.
module ringbuffer_multimode
  import ringbuffer_pkg::*;
#(
  parameter int AW          = 2,
  parameter int DW          = 8,
  parameter int MODE        = RB_MODE_DROP,
  parameter int ALMOST_FULL = 3,
  parameter int CW          = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] write_data,
  input  logic          write_clock_enable,
  input  logic          read_clock_enable,
  input  logic          overflow_clear,
  output logic [DW-1:0] read_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          almost_full,
  output logic          overflow,
  output logic          underflow,
  output logic [CW-1:0] drop_count
);

  localparam int DEPTH = rb_depth(AW);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL = (AW+1)'(ALMOST_FULL);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic OVW = (MODE == RB_MODE_OVERWRITE);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   lvl;
  logic          rd_ok;
  logic          drop;
  logic          wr_ok;
  logic          grow;
  logic          rptr_adv;
  logic          unf_ev;

  assign level       = lvl;
  assign empty       = (lvl == '0);
  assign full        = (lvl == FULL_LVL);
  assign almost_full = (lvl >= AF_LVL);

  // A write into a full buffer only loses data if no read frees a slot.
  assign rd_ok    = read_clock_enable && !empty;
  assign drop     = write_clock_enable && full && !rd_ok;
  assign wr_ok    = write_clock_enable && (!drop || OVW);
  assign grow     = write_clock_enable && !drop;
  assign rptr_adv = rd_ok || (drop && OVW);
  assign unf_ev   = read_clock_enable && empty;

  ringbuffer_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clock(clock),
    .reset(reset),
    .we   (wr_ok),
    .waddr(wptr),
    .wdata(write_data),
    .re   (rd_ok),
    .raddr(rptr),
    .rdata(read_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
    end else begin
      if (wr_ok)    wptr <= wptr + 1'b1;
      if (rptr_adv) rptr <= rptr + 1'b1;
      if (grow && !rd_ok)      lvl <= lvl + 1'b1;
      else if (!grow && rd_ok) lvl <= lvl - 1'b1;
    end
  end

  // A new event in the clearing cycle takes precedence over the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      drop_count <= '0;
    end else if (overflow_clear) begin
      overflow   <= drop;
      underflow  <= unf_ev;
      drop_count <= drop ? CW'(1) : '0;
    end else begin
      overflow  <= overflow | drop;
      underflow <= underflow | unf_ev;
      if (drop && drop_count != CNT_MAX)
        drop_count <= drop_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_ringbuffer_multimode.sv
// Checks drop and overwrite instances side by side against
// a queue-based reference, with vector tables and directed cases.
module tb_ringbuffer_multimode;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] write_data = '0;
  logic       wce = 1'b0;
  logic       rce = 1'b0;
  logic       clr = 1'b0;

  logic [7:0] rdat [2];
  logic       emp  [2];
  logic       ful  [2];
  logic [2:0] lvl  [2];
  logic       af   [2];
  logic       ovf  [2];
  logic       unf  [2];
  logic [7:0] cnt  [2];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ringbuffer_multimode #(
    .AW(2), .DW(8), .MODE(0), .ALMOST_FULL(3), .CW(8)
  ) dut0 (
    .clock(clock), .reset(reset),
    .write_data(write_data),
    .write_clock_enable(wce),
    .read_clock_enable(rce),
    .overflow_clear(clr),
    .read_data(rdat[0]), .empty(emp[0]), .full(ful[0]),
    .level(lvl[0]), .almost_full(af[0]),
    .overflow(ovf[0]), .underflow(unf[0]),
    .drop_count(cnt[0])
  );

  ringbuffer_multimode #(
    .AW(2), .DW(8), .MODE(1), .ALMOST_FULL(3), .CW(8)
  ) dut1 (
    .clock(clock), .reset(reset),
    .write_data(write_data),
    .write_clock_enable(wce),
    .read_clock_enable(rce),
    .overflow_clear(clr),
    .read_data(rdat[1]), .empty(emp[1]), .full(ful[1]),
    .level(lvl[1]), .almost_full(af[1]),
    .overflow(ovf[1]), .underflow(unf[1]),
    .drop_count(cnt[1])
  );

  // reference model: a queue of stored words per policy
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int m_rd  [2];
  int m_ovf [2];
  int m_unf [2];
  int m_cnt [2];

  function automatic int qsize(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int m, input logic [7:0] v);
    if (m == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  task automatic qpop(input int m, output logic [7:0] v);
    if (m == 0) v = q0.pop_front();
    else v = q1.pop_front();
  endtask

  task automatic model_step(input int m, input logic w,
                            input logic [7:0] d, input logic r,
                            input logic c, input logic rs);
    int sz;
    bit rok, uev, oev;
    logic [7:0] v;
    if (rs) begin
      if (m == 0) q0.delete();
      else q1.delete();
      m_rd[m] = 0; m_ovf[m] = 0; m_unf[m] = 0; m_cnt[m] = 0;
      return;
    end
    sz  = qsize(m);
    rok = r && sz > 0;
    uev = r && sz == 0;
    oev = w && sz == 4 && !rok;
    if (rok) begin
      qpop(m, v);
      m_rd[m] = int'(v);
    end
    if (w) begin
      if (qsize(m) < 4) qpush(m, d);
      else if (m == 1) begin
        qpop(m, v);
        qpush(m, d);
      end
    end
    if (c) begin
      m_ovf[m] = oev ? 1 : 0;
      m_unf[m] = uev ? 1 : 0;
      m_cnt[m] = oev ? 1 : 0;
    end else begin
      if (oev) m_ovf[m] = 1;
      if (uev) m_unf[m] = 1;
      if (oev && m_cnt[m] < 255) m_cnt[m]++;
    end
  endtask

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic model_check();
    for (int m = 0; m < 2; m++) begin
      int sz;
      sz = qsize(m);
      chk($sformatf("m%0d_level", m), 32'(lvl[m]), 32'(sz));
      chk($sformatf("m%0d_empty", m), 32'(emp[m]), 32'(sz == 0));
      chk($sformatf("m%0d_full", m), 32'(ful[m]), 32'(sz == 4));
      chk($sformatf("m%0d_afull", m), 32'(af[m]), 32'(sz >= 3));
      chk($sformatf("m%0d_rdata", m), 32'(rdat[m]), 32'(m_rd[m]));
      chk($sformatf("m%0d_ovf", m), 32'(ovf[m]), 32'(m_ovf[m]));
      chk($sformatf("m%0d_unf", m), 32'(unf[m]), 32'(m_unf[m]));
      chk($sformatf("m%0d_cnt", m), 32'(cnt[m]), 32'(m_cnt[m]));
    end
  endtask

  task automatic step(input logic w, input logic [7:0] d,
                      input logic r, input logic c,
                      input logic rs);
    write_data = d; wce = w; rce = r; clr = c; reset = rs;
    @(posedge clock);
    #1;
    model_step(0, w, d, r, c, rs);
    model_step(1, w, d, r, c, rs);
    model_check();
  endtask

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic       c;
    logic       rs;
    logic [7:0] e_rd;
    logic [2:0] e_lvl;
    logic       e_ovf;
    logic       e_unf;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [7:0] prev;

    // drop-mode plan, expectations for dut0
    vt[0]  = '{0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0, 0};
    vt[1]  = '{0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 0};
    vt[2]  = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0};
    vt[3]  = '{1, 8'hA1, 0, 0, 0, 8'h00, 1, 0, 0, 0};
    vt[4]  = '{1, 8'hA2, 0, 0, 0, 8'h00, 2, 0, 0, 0};
    vt[5]  = '{1, 8'hA3, 0, 0, 0, 8'h00, 3, 0, 0, 0};
    vt[6]  = '{1, 8'hA4, 0, 0, 0, 8'h00, 4, 0, 0, 0};
    vt[7]  = '{1, 8'hA5, 0, 0, 0, 8'h00, 4, 1, 0, 1};
    vt[8]  = '{0, 8'h00, 1, 0, 0, 8'hA1, 3, 1, 0, 1};
    vt[9]  = '{0, 8'h00, 1, 0, 0, 8'hA2, 2, 1, 0, 1};
    vt[10] = '{0, 8'h00, 1, 0, 0, 8'hA3, 1, 1, 0, 1};
    vt[11] = '{0, 8'h00, 1, 0, 0, 8'hA4, 0, 1, 0, 1};

    for (int i = 0; i < 12; i++) begin
      step(vt[i].w, vt[i].d, vt[i].r, vt[i].c, vt[i].rs);
      chk($sformatf("v%0d_rdata", i), 32'(rdat[0]), 32'(vt[i].e_rd));
      chk($sformatf("v%0d_level", i), 32'(lvl[0]), 32'(vt[i].e_lvl));
      chk($sformatf("v%0d_afull", i), 32'(af[0]),
          32'(vt[i].e_lvl >= 3'd3));
      chk($sformatf("v%0d_full", i), 32'(ful[0]),
          32'(vt[i].e_lvl == 3'd4));
      chk($sformatf("v%0d_empty", i), 32'(emp[0]),
          32'(vt[i].e_lvl == 3'd0));
      chk($sformatf("v%0d_ovf", i), 32'(ovf[0]), 32'(vt[i].e_ovf));
      chk($sformatf("v%0d_unf", i), 32'(unf[0]), 32'(vt[i].e_unf));
      chk($sformatf("v%0d_cnt", i), 32'(cnt[0]), 32'(vt[i].e_cnt));
    end

    // overwrite mode keeps the newest four words
    step(0, 8'h00, 0, 1, 0);
    for (int i = 1; i <= 6; i++) step(1, 8'(8'hB0 + i), 0, 0, 0);
    chk("ovw_ovf", 32'(ovf[1]), 32'd1);
    chk("ovw_cnt", 32'(cnt[1]), 32'd2);
    chk("ovw_level", 32'(lvl[1]), 32'd4);
    for (int i = 3; i <= 6; i++) begin
      step(0, 8'h00, 1, 0, 0);
      chk($sformatf("ovw_rd%0d", i), 32'(rdat[1]), 32'(8'hB0 + i));
    end

    // full buffer, read and write together
    step(0, 8'h00, 0, 1, 0);
    for (int i = 1; i <= 4; i++) step(1, 8'(8'hC0 + i), 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step(1, 8'hC5, 1, 0, 0);
      chk($sformatf("rw_ovf%0d", i), 32'(ovf[0]), 32'd0);
      chk($sformatf("rw_lvl%0d", i), 32'(lvl[0]), 32'd4);
      chk($sformatf("rw_rd%0d", i), 32'(rdat[0]), 32'(8'hC0 + i));
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);

    // empty buffer, read and write together
    prev = rdat[0];
    step(1, 8'hD1, 1, 0, 0);
    chk("er_level", 32'(lvl[0]), 32'd1);
    chk("er_rdata", 32'(rdat[0]), 32'(prev));
    chk("er_unf", 32'(unf[0]), 32'd1);
    step(0, 8'h00, 1, 0, 0);
    chk("er_rd", 32'(rdat[0]), 32'hD1);

    // drop counter saturation and clear/event collision
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 8'(8'hE0 + i), 0, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 8'(i), 0, 0, 0);
    chk("sat_cnt0", 32'(cnt[0]), 32'hFF);
    chk("sat_cnt1", 32'(cnt[1]), 32'hFF);
    step(1, 8'h55, 0, 1, 0);
    chk("clr_ovf0", 32'(ovf[0]), 32'd1);
    chk("clr_cnt0", 32'(cnt[0]), 32'd1);
    chk("clr_cnt1", 32'(cnt[1]), 32'd1);
    step(1, 8'h66, 1, 0, 0);
    step(0, 8'h00, 1, 0, 1);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst%0d_rd", m), 32'(rdat[m]), 32'd0);
      chk($sformatf("rst%0d_lvl", m), 32'(lvl[m]), 32'd0);
      chk($sformatf("rst%0d_emp", m), 32'(emp[m]), 32'd1);
      chk($sformatf("rst%0d_full", m), 32'(ful[m]), 32'd0);
      chk($sformatf("rst%0d_af", m), 32'(af[m]), 32'd0);
      chk($sformatf("rst%0d_ovf", m), 32'(ovf[m]), 32'd0);
      chk($sformatf("rst%0d_unf", m), 32'(unf[m]), 32'd0);
      chk($sformatf("rst%0d_cnt", m), 32'(cnt[m]), 32'd0);
    end

    // random traffic against the queue model
    for (int i = 0; i < 1500; i++) begin
      logic w, r, c, rs;
      w  = ($urandom_range(99) < 55);
      r  = ($urandom_range(99) < 45);
      c  = ($urandom_range(99) < 4);
      rs = ($urandom_range(999) < 5);
      step(w, 8'($urandom), r, c, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
